// File: rtl/nabp_filtered_line_swap.sv
// Double-buffered filtered projection line store: the filter stage fills one bank
// while two independent read ports random-access the other bank by s value.
module nabp_filtered_line_swap #(
    parameter int DATA_WIDTH  = 16,
    parameter int S_WIDTH     = 9,
    parameter int ANGLE_WIDTH = 9,
    parameter int LINE_SIZE   = 256
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [DATA_WIDTH-1:0]  fl_data,
    input  logic [ANGLE_WIDTH-1:0] fl_angle,
    input  logic                   fl_valid,
    output logic                   fl_ready,
    output logic                   pv_valid,
    output logic [ANGLE_WIDTH-1:0] pv_angle,
    input  logic                   pv_next,
    input  logic [S_WIDTH-1:0]     pv0_s_val,
    input  logic [S_WIDTH-1:0]     pv1_s_val,
    output logic [DATA_WIDTH-1:0]  pv0_val,
    output logic [DATA_WIDTH-1:0]  pv1_val
);

    // state      | meaning
    // ST_EMPTY   | bank free, next accepted word starts a new line
    // ST_FILLING | line partially written
    // ST_FULL    | line complete, waiting for the read pointer
    // ST_READING | line exposed to the processing side
    typedef enum logic [1:0] {ST_EMPTY, ST_FILLING, ST_FULL, ST_READING} bank_state_t;

    localparam int AW    = (LINE_SIZE > 1) ? $clog2(LINE_SIZE) : 1;
    localparam int DEPTH = 1 << AW;
    localparam logic [S_WIDTH-1:0] LAST_ADDR  = S_WIDTH'(LINE_SIZE - 1);
    localparam logic [S_WIDTH:0]   LINE_LIMIT = (S_WIDTH + 1)'(LINE_SIZE);

    bank_state_t            state_q [2];
    bank_state_t            state_d [2];
    logic                   wbank_q, wbank_d;
    logic                   rbank_q, rbank_d;
    logic [S_WIDTH-1:0]     waddr_q, waddr_d;
    logic [ANGLE_WIDTH-1:0] angle_q [2];
    logic [DATA_WIDTH-1:0]  mem [2][DEPTH];

    logic accept;
    logic last_word;
    logic release_bank;
    logic rd0_ok;
    logic rd1_ok;

    assign fl_ready     = (state_q[wbank_q] == ST_EMPTY) || (state_q[wbank_q] == ST_FILLING);
    assign pv_valid     = (state_q[rbank_q] == ST_READING);
    assign pv_angle     = angle_q[rbank_q];
    assign accept       = fl_valid && fl_ready;
    assign last_word    = (waddr_q == LAST_ADDR);
    assign release_bank = pv_next && pv_valid;
    assign rd0_ok       = pv_valid && ({1'b0, pv0_s_val} < LINE_LIMIT);
    assign rd1_ok       = pv_valid && ({1'b0, pv1_s_val} < LINE_LIMIT);

    always_ff @(posedge clk or posedge reset_n) begin
        if (reset_n) begin
            state_q[0] <= ST_EMPTY;
            state_q[1] <= ST_EMPTY;
            wbank_q    <= 1'b0;
            rbank_q    <= 1'b0;
            waddr_q    <= '0;
            angle_q[0] <= '0;
            angle_q[1] <= '0;
            pv0_val    <= '0;
            pv1_val    <= '0;
        end else begin
            state_q[0] <= state_d[0];
            state_q[1] <= state_d[1];
            wbank_q    <= wbank_d;
            rbank_q    <= rbank_d;
            waddr_q    <= waddr_d;
            if (accept && (waddr_q == '0)) begin
                angle_q[wbank_q] <= fl_angle;
            end
            pv0_val <= rd0_ok ? mem[rbank_q][pv0_s_val[AW-1:0]] : '0;
            pv1_val <= rd1_ok ? mem[rbank_q][pv1_s_val[AW-1:0]] : '0;
        end
    end

    // Storage is deliberately left uncleared by reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            mem[wbank_q][waddr_q[AW-1:0]] <= fl_data;
        end
    end

    // Write and read sides never touch the same bank in the same way: accept needs
    // EMPTY/FILLING, promotion needs FULL, release needs READING.
    always_comb begin
        state_d[0] = state_q[0];
        state_d[1] = state_q[1];
        wbank_d    = wbank_q;
        rbank_d    = rbank_q;
        waddr_d    = waddr_q;

        if (state_q[rbank_q] == ST_FULL) begin
            state_d[rbank_q] = ST_READING;
        end
        if (release_bank) begin
            state_d[rbank_q] = ST_EMPTY;
            rbank_d          = ~rbank_q;
        end

        if (accept) begin
            if (last_word) begin
                state_d[wbank_q] = ST_FULL;
                waddr_d          = '0;
                wbank_d          = ~wbank_q;
            end else begin
                waddr_d = waddr_q + 1'b1;
                if (waddr_q == '0) begin
                    state_d[wbank_q] = ST_FILLING;
                end
            end
        end
    end

endmodule

// File: doc/nabp_filtered_line_swap.md
# nabp_filtered_line_swap

Double-buffered filtered-projection line store sitting between the filter stage and the processing swappables. The filter stage streams one filtered projection line per angle into the write bank. The processing side random-reads the other bank by `s` value through two independent read ports, one per processing swappable. Banks swap on a bank-state handshake, so filling of angle n+1 overlaps backprojection of angle n.

## Interface
Parameters:
- `DATA_WIDTH`, 16: filtered sample width (`kFilteredDataLength`).
- `S_WIDTH`, 9: projection-line address width (`kSLength`).
- `ANGLE_WIDTH`, 9: angle tag width (`kAngleLength`).
- `LINE_SIZE`, 256: samples per projection line; must be ≤ 2^S_WIDTH.

Ports:
- `clk`  in  1  clock
- `reset_n`  in  1  reset, asynchronous, active-high
- `fl_data`  in  DATA_WIDTH  filtered sample from filter stage
- `fl_angle`  in  ANGLE_WIDTH  angle of the line being streamed; sampled with word 0
- `fl_valid`  in  1  sample valid
- `fl_ready`  out  1  store can accept a sample
- `pv_valid`  out  1  read bank holds a complete line
- `pv_angle`  out  ANGLE_WIDTH  angle tag of read bank
- `pv_next`  in  1  pulse: consumer done with read bank
- `pv0_s_val`, `pv1_s_val`  in  S_WIDTH  read addresses
- `pv0_val`, `pv1_val`  out  DATA_WIDTH  read data

## Operation
- Two banks of LINE_SIZE×DATA_WIDTH plus a per-bank angle register and 2-bit state: EMPTY, FILLING, FULL, READING.
- Pointers: `wbank`, `rbank` (1 bit each), `waddr` (S_WIDTH bits).
- `fl_ready` = state[wbank] ∈ {EMPTY, FILLING}. It is combinational from registered state.
- Accept (`fl_valid && fl_ready`):
  - Write `mem[wbank][waddr]` and increment `waddr`.
  - If `waddr==0`: latch `fl_angle` into angle[wbank] and move EMPTY→FILLING.
  - If `waddr==LINE_SIZE-1`: move state to FULL, set `waddr` to 0, toggle `wbank`.
- Read promotion: if state[rbank]==FULL, move it to READING on the next edge.
- `pv_valid` = state[rbank]==READING. `pv_angle` = angle[rbank].
- `pv_next`:
  - With `pv_valid` high: state[rbank] goes READING→EMPTY and `rbank` toggles.
  - With `pv_valid` low: ignored.
- Read ports:
  - `pvN_val` is registered, taking `mem[rbank][pvN_s_val]` when `pv_valid` is high and `pvN_s_val < LINE_SIZE`. Otherwise it takes 0.
  - Both ports are fully independent; both may read the same address in the same cycle.
- Write and read banks are always distinct while reading. A write never targets a FULL or READING bank.
- Simultaneous last-word accept on one bank and `pv_next` on the other: both transitions take effect on that edge.
- Release and stall: if `wbank` points at the released bank, `fl_ready` rises in the cycle after the `pv_next` edge.
- Reset (any time, including mid-line):
  - Both states EMPTY; `wbank`=`rbank`=0; `waddr`=0; angles 0.
  - `pv0_val`=`pv1_val`=0; therefore `fl_ready`=1 and `pv_valid`=0.
  - Memory contents are not cleared.
  - A partial line is discarded.

## Timing
- Write: 0-cycle accept. Data is written on the accepting edge.
- Line completion: last word accepted on edge E → FULL after E.
  - If the bank is `rbank`: READING and `pv_valid`=1 after E+1.
  - Otherwise it waits in FULL until `rbank` reaches it, then promotes one edge later.
- Read latency: 1 cycle. Address presented before edge R → `pvN_val` valid after R.
- `pv_next` sampled on edge P → `pv_valid` low after P, unless the other bank is already READING-eligible. In that case `pv_valid` rises after P+1 (one-cycle gap minimum).
- Throughput: one sample per cycle sustained when the consumer releases banks within one line time.
- After the second completed line without a release, `fl_ready` is low until the release edge.

## Test plan
- Fill one line, `fl_data`=index, `fl_angle`=30 → `pv_valid` high 2 edges after last accept, `pv_angle`=30. Then `pv0_s_val`=5, `pv1_s_val`=200 → `pv0_val`=5, `pv1_val`=200 one cycle later.
- Stream three lines back-to-back (angles 0, 1, 2) with no `pv_next` → `fl_ready` drops after line 1 completes (line 0 READING, line 1 FULL). Then `pv_next` → `pv_angle`=1 after 2 edges, `fl_ready`=1, line 2 fills into bank 0.
- `pv0_s_val`=LINE_SIZE (256) and `pv1_s_val`=511 while valid → both outputs 0. Reads while `pv_valid`=0 → 0.
- Assert reset for 1 cycle at word 100 of a fill → `fl_ready`=1, `pv_valid`=0, outputs 0. A fresh full line then reads back correctly with the new angle.
- `pv_next` on the same edge as the last-word accept of the other bank → released bank is EMPTY and the new bank reads READING one edge later. No sample is lost.
- Random `fl_valid` gaps (50%) and random read addresses over 8 lines → every read matches the scoreboard of the written line and angle.
